// File: rtl/captura_clave_teclado.sv
// Keypad PIN capture: collects four decimal digits and delivers them as a 16-bit word,
// handling clear, early Enter and idle timeout so only complete PINs reach the access controller.
module captura_clave_teclado #(
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        habilitar,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  input  logic        tecla_enter,
  input  logic        tecla_borrar,
  output logic [15:0] clave_ingresada,
  output logic        clave_lista,
  output logic [2:0]  num_digitos,
  output logic        error_incompleta,
  output logic        error_timeout
);

  localparam int unsigned TIMER_W  = 16;
  localparam int unsigned DIGITS_W = 3;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CAPTURA  = 2'd1,
    COMPLETA = 2'd2,
    ENTREGA  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [15:0]         buffer, buffer_n;
  logic [DIGITS_W-1:0] count_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [15:0]         clave_n;
  logic                lista_n, err_inc_n, err_to_n;
  logic                digito;

  assign digito = tecla_valida && (tecla <= 4'd9) && (state == CAPTURA);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= INACTIVO;
      buffer           <= 16'd0;
      num_digitos      <= '0;
      timer            <= '0;
      clave_ingresada  <= 16'd0;
      clave_lista      <= 1'b0;
      error_incompleta <= 1'b0;
      error_timeout    <= 1'b0;
    end else begin
      state            <= state_n;
      buffer           <= buffer_n;
      num_digitos      <= count_n;
      timer            <= timer_n;
      clave_ingresada  <= clave_n;
      clave_lista      <= lista_n;
      error_incompleta <= err_inc_n;
      error_timeout    <= err_to_n;
    end
  end

  // Next-state logic; priority is habilitar, borrar, enter, digit, then timeout
  always_comb begin
    state_n   = state;
    buffer_n  = buffer;
    count_n   = num_digitos;
    timer_n   = timer;
    clave_n   = clave_ingresada;
    lista_n   = 1'b0;
    err_inc_n = 1'b0;
    err_to_n  = 1'b0;

    if (!habilitar) begin
      state_n  = INACTIVO;
      buffer_n = 16'd0;
      count_n  = '0;
      timer_n  = '0;
    end else begin
      case (state)
        INACTIVO: begin
          state_n = CAPTURA;
        end
        CAPTURA, COMPLETA: begin
          if (tecla_borrar) begin
            state_n  = CAPTURA;
            buffer_n = 16'd0;
            count_n  = '0;
            timer_n  = '0;
          end else if (tecla_enter) begin
            timer_n = '0;
            if (state == COMPLETA) begin
              clave_n = buffer;
              lista_n = 1'b1;
              state_n = ENTREGA;
            end else begin
              buffer_n  = 16'd0;
              count_n   = '0;
              err_inc_n = 1'b1;
            end
          end else if (digito) begin
            buffer_n = {buffer[11:0], tecla};
            count_n  = num_digitos + DIGITS_W'(1);
            timer_n  = '0;
            if (num_digitos == DIGITS_W'(3)) state_n = COMPLETA;
          end else if (num_digitos != '0) begin
            if (timer == TIMER_W'(TIMEOUT_CICLOS - 1)) begin
              state_n  = CAPTURA;
              buffer_n = 16'd0;
              count_n  = '0;
              timer_n  = '0;
              err_to_n = 1'b1;
            end else begin
              timer_n = timer + TIMER_W'(1);
            end
          end else begin
            timer_n = '0;
          end
        end
        ENTREGA: begin
          state_n  = CAPTURA;
          buffer_n = 16'd0;
          count_n  = '0;
          timer_n  = '0;
        end
        default: begin
          state_n  = INACTIVO;
          buffer_n = 16'd0;
          count_n  = '0;
          timer_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_captura_clave_teclado.sv
// Directed bench for captura_clave_teclado with a short timeout.
module tb_captura_clave_teclado;

  logic        clk = 1'b0;
  logic        reset;
  logic        habilitar;
  logic        tecla_valida;
  logic [3:0]  tecla;
  logic        tecla_enter;
  logic        tecla_borrar;
  logic [15:0] clave_ingresada;
  logic        clave_lista;
  logic [2:0]  num_digitos;
  logic        error_incompleta;
  logic        error_timeout;

  int errors = 0;
  int checks = 0;

  captura_clave_teclado #(.TIMEOUT_CICLOS(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .habilitar        (habilitar),
    .tecla_valida     (tecla_valida),
    .tecla            (tecla),
    .tecla_enter      (tecla_enter),
    .tecla_borrar     (tecla_borrar),
    .clave_ingresada  (clave_ingresada),
    .clave_lista      (clave_lista),
    .num_digitos      (num_digitos),
    .error_incompleta (error_incompleta),
    .error_timeout    (error_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes, then sample 1 time unit after the edge
  task automatic step(input logic v, input logic [3:0] d, input logic e, input logic b);
    tecla_valida = v;
    tecla        = d;
    tecla_enter  = e;
    tecla_borrar = b;
    @(posedge clk);
    #1;
    tecla_valida = 1'b0;
    tecla_enter  = 1'b0;
    tecla_borrar = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_all(input string tag, input logic [15:0] clave, input logic lista,
                           input logic [2:0] num, input logic einc, input logic eto);
    check({tag, ".clave"}, clave_ingresada, clave);
    check({tag, ".lista"}, 16'(clave_lista), 16'(lista));
    check({tag, ".num"}, 16'(num_digitos), 16'(num));
    check({tag, ".einc"}, 16'(error_incompleta), 16'(einc));
    check({tag, ".eto"}, 16'(error_timeout), 16'(eto));
  endtask

  initial begin
    reset = 1'b1; habilitar = 1'b0;
    tecla_valida = 1'b0; tecla = 4'h0; tecla_enter = 1'b0; tecla_borrar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0; habilitar = 1'b1;
    idle();
    check_all("enable", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);

    // 1,1,9,4 Enter
    key(4'h1); check("t1.n1", 16'(num_digitos), 16'd1);
    key(4'h1); check("t1.n2", 16'(num_digitos), 16'd2);
    key(4'h9); check("t1.n3", 16'(num_digitos), 16'd3);
    key(4'h4); check("t1.n4", 16'(num_digitos), 16'd4);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("t1.deliver", 16'h1194, 1'b1, 3'd4, 1'b0, 1'b0);
    idle();
    check_all("t1.after", 16'h1194, 1'b0, 3'd0, 1'b0, 1'b0);

    // Extra digits and a non-digit code are ignored
    key(4'h1); key(4'h2);
    key(4'hB); check("t2.hex", 16'(num_digitos), 16'd2);
    key(4'h3); key(4'h4);
    key(4'h5); key(4'h6); check("t2.full", 16'(num_digitos), 16'd4);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("t2.deliver", 16'h1234, 1'b1, 3'd4, 1'b0, 1'b0);
    idle();
    check("t2.lista_off", 16'(clave_lista), 16'd0);

    // Early Enter
    key(4'h7); key(4'h7);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("t3.early", 16'h1234, 1'b0, 3'd0, 1'b1, 1'b0);
    idle();
    check("t3.einc_off", 16'(error_incompleta), 16'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("t3.empty", 16'h1234, 1'b0, 3'd0, 1'b1, 1'b0);
    idle();

    // Timeout fires on the 8th idle edge after the digit
    key(4'h3);
    for (int i = 1; i <= 8; i++) begin
      idle();
      check($sformatf("t4.eto%0d", i), 16'(error_timeout), 16'(i == 8));
    end
    check("t4.num", 16'(num_digitos), 16'd0);
    idle();
    check("t4.eto_off", 16'(error_timeout), 16'd0);

    // A digit on idle cycle 7 reloads the counter
    key(4'h3);
    for (int i = 1; i <= 6; i++) idle();
    key(4'h5);
    check("t4b.num", 16'(num_digitos), 16'd2);
    for (int i = 1; i <= 8; i++) begin
      idle();
      check($sformatf("t4b.eto%0d", i), 16'(error_timeout), 16'(i == 8));
    end
    check("t4b.num0", 16'(num_digitos), 16'd0);

    // Clear beats a simultaneous digit
    key(4'h1); key(4'h2);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    check_all("t5.clear", 16'h1234, 1'b0, 3'd0, 1'b0, 1'b0);
    key(4'h4); key(4'h3); key(4'h2); key(4'h1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("t5.deliver", 16'h4321, 1'b1, 3'd4, 1'b0, 1'b0);
    idle();

    // Drop habilitar, then reset mid-entry
    key(4'h1); key(4'h2); key(4'h3);
    habilitar = 1'b0;
    idle();
    check_all("t6.disable", 16'h4321, 1'b0, 3'd0, 1'b0, 1'b0);
    habilitar = 1'b1;
    idle();
    key(4'h8); key(4'h8);
    check("t6.num2", 16'(num_digitos), 16'd2);
    reset = 1'b1;
    idle();
    check_all("t6.reset", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
